cmd_sequencer: RTL and testbench
================================

Name: cmd_sequencer

Overview:
- Sits directly behind the UART command wrapper.
- Consumes each assembled 3-byte command (cmd + 16-bit data), decodes it, and applies it to a small configuration register file or strobe bus.
- Sequences the 1- or 2-byte response back through the wrapper's snd_resp/resp/resp_sent handshake.
- Also arbitrates the single TX response path between command responses and asynchronous event reports from the rest of the design.

Parameters:
- NREGS, 8, number of 16-bit config registers (max 8; indexed by cmd[2:0]).
- TO_CYCLES, 1_000_000, cycles to wait for resp_sent before aborting a send.
- TO_W, 20, width of the timeout counter (must hold TO_CYCLES).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cmd_rdy  input  1  level; the wrapper holds a complete command
- cmd  input  8  opcode [7:6], reserved [5:3], index [2:0]
- data  input  16  command payload; low byte is live, so it is valid only while cmd_rdy=1 before the next byte arrives
- clr_cmd_rdy  output  1  1-cycle pulse acknowledging the command
- snd_resp  output  1  1-cycle pulse starting transmission of resp
- resp  output  8  response byte, held stable from snd_resp through resp_sent
- resp_sent  input  1  UART TX done; level, cleared by the UART on the edge that samples snd_resp
- evt_req  input  1  1-cycle event request from other blocks
- evt_code  input  4  event code, sampled with evt_req
- regs_out  output  NREGS*16  flattened register file; reg i is at [16i+15:16i]
- strb  output  NREGS  one-hot 1-cycle strobe
- tx_err  output  1  1-cycle pulse on response timeout

Behaviour:
- Reset values: all outputs 0, all regs 0, evt_pend=0, last_evt=0, state IDLE.
- Opcodes:
  - 00 WRITE: reg[idx] <= data; response ACK 0xA5.
  - 01 READ: response reg[idx][15:8], then reg[idx][7:0].
  - 10 STROBE: strb[idx] high 1 cycle; response ACK 0xA5.
  - 11 or idx>=NREGS: no side effect; response NAK 0x5A.
- States: IDLE, EXEC, SEND, WAIT, SEND2, WAIT2, ESEND, EWAIT.
- IDLE arbitration:
  - Command is eligible when cmd_rdy=1; event is eligible when evt_pend=1.
  - Only one eligible: serve it.
  - Both eligible: serve the event if last_evt=0, else serve the command (round-robin).
  - last_evt <= 1 when an event is served, 0 when a command is served.
- Command accept (IDLE):
  - Same cycle: capture cmd and data into internal regs, pulse clr_cmd_rdy. Next state EXEC.
  - All later steps use the captured copy only.
- EXEC, one cycle:
  - Perform the write or strobe; strb asserts in this cycle.
  - Load resp with the first response byte. Next state SEND.
- SEND: snd_resp=1 for 1 cycle, then WAIT.
- WAIT:
  - On the first cycle with resp_sent=1: go to SEND2 (READ) or IDLE (otherwise).
  - For READ, resp is loaded with the low byte on that same cycle.
- SEND2/WAIT2: same handshake as SEND/WAIT, then IDLE.
- Latency:
  - cmd_rdy to clr_cmd_rdy: 0 cycles when in IDLE.
  - cmd_rdy to first snd_resp: 2 cycles.
  - WRITE to regs_out update: visible the cycle after EXEC.
- Event path:
  - evt_req=1 sets evt_pend and latches evt_code.
  - A further evt_req while pending overwrites the code; one report only.
  - Serving an event: resp <= {4'hE, code}, clear evt_pend, go to ESEND, then EWAIT (same handshake as SEND/WAIT).
  - evt_req in the same cycle as its pending event is cleared: the new request wins and pend stays 1.
- Timeout:
  - A counter runs in every WAIT state and resets on state entry.
  - Reaching TO_CYCLES-1 with no resp_sent: pulse tx_err, go to IDLE, drop any remaining READ byte.
- cmd_rdy arriving while busy is held by the wrapper and served later; never lost.
- Asynchronous reset mid-operation returns everything to reset values immediately; a partially sent response is abandoned.
- Register writes occur only in EXEC; there is no other write path.

Decomposition:
- Package cmd_seq_pkg holds:
  - opcode enum (OP_WRITE, OP_READ, OP_STROBE, OP_RSVD)
  - ACK=8'hA5, NAK=8'h5A, EVT_HDR=4'hE
  - state enum
- Sub-module resp_timeout_cnt: clear/enable inputs, expired output, parameterised by TO_CYCLES/TO_W.
- FSM, arbiter and register file stay in cmd_sequencer.

Test Plan:
- WRITE: cmd=0x03, data=0x1234 → clr_cmd_rdy pulse, regs_out[63:48]=0x1234, resp=0xA5 sent once.
- READ: after the write above, cmd=0x43 → two snd_resp pulses with resp 0x12 then 0x34; second pulse only after the first resp_sent.
- STROBE and NAK:
  - cmd=0x85 → strb=8'h20 for exactly 1 cycle, ACK.
  - cmd=0xC0 → NAK 0x5A, no reg or strb change.
- Arbitration:
  - evt_req with code 0x7 while a READ is in progress, plus a second command queued → after the READ, 0xE7 is sent before the queued command's response.
  - An event arriving while a further event is already pending is overwritten, not queued: only the latest code is reported, once.
- Timeout: TO_CYCLES=16, resp_sent held 0 → tx_err pulses 16 cycles after WAIT entry, FSM returns to IDLE, next command is served normally.
- Reset mid-READ: deassert rst_n between the two bytes → all outputs 0, regs cleared, no second snd_resp after release.

Source files
------------

// File: rtl/cmd_seq_pkg.sv
// Shared types and constants for the UART command sequencer.
package cmd_seq_pkg;

    localparam int unsigned CMD_W  = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned RESP_W = 8;

    localparam logic [RESP_W-1:0] ACK     = 8'hA5;
    localparam logic [RESP_W-1:0] NAK     = 8'h5A;
    localparam logic [3:0]        EVT_HDR = 4'hE;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_READ   = 2'b01,
        OP_STROBE = 2'b10,
        OP_RSVD   = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE, EXEC, SEND, WAIT, SEND2, WAIT2, ESEND, EWAIT
    } state_e;

    // Command byte layout as delivered by the wrapper.
    typedef struct packed {
        opcode_e          op;
        logic [2:0]       rsvd;
        logic [IDX_W-1:0] idx;
    } cmd_t;

    // A command is refused when its opcode is reserved or it names a missing register.
    function automatic logic cmd_is_nak(input cmd_t c, input int unsigned nregs);
        return (c.op == OP_RSVD) || (32'(c.idx) >= nregs);
    endfunction

endpackage

// File: rtl/resp_timeout_cnt.sv
// Response-wait watchdog: counts cycles spent waiting for resp_sent.
module resp_timeout_cnt #(
    parameter int unsigned TO_CYCLES = 1_000_000,
    parameter int unsigned TO_W      = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TO_CYCLES - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            expired_q, expired_d;

    // Count while enabled, saturating at the last cycle; expired marks the cycle count == LAST.
    always_comb begin
        cnt_d     = cnt_q;
        expired_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q != LAST) begin
                cnt_d = cnt_q + TO_W'(1);
            end
            expired_d = (cnt_d == LAST);
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/cmd_sequencer.sv
// Decodes wrapper commands, drives the register file/strobes and sequences responses and event reports.
module cmd_sequencer
    import cmd_seq_pkg::*;
#(
    parameter int unsigned NREGS     = 8,
    parameter int unsigned TO_CYCLES = 1_000_000,
    parameter int unsigned TO_W      = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_rdy,
    input  logic [CMD_W-1:0]        cmd,
    input  logic [DATA_W-1:0]       data,
    output logic                    clr_cmd_rdy,
    output logic                    snd_resp,
    output logic [RESP_W-1:0]       resp,
    input  logic                    resp_sent,
    input  logic                    evt_req,
    input  logic [3:0]              evt_code,
    output logic [NREGS*DATA_W-1:0] regs_out,
    output logic [NREGS-1:0]        strb,
    output logic                    tx_err
);

    state_e              state_q, state_d;
    cmd_t                cmd_q, cmd_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [RESP_W-1:0]   resp_q, resp_d;
    logic                snd_resp_q, snd_resp_d;
    logic [NREGS-1:0]    strb_q, strb_d;
    logic                tx_err_q, tx_err_d;
    logic                evt_pend_q, evt_pend_d;
    logic [3:0]          evt_code_q, evt_code_d;
    logic                last_evt_q, last_evt_d;
    logic [DATA_W-1:0]   regs_q [NREGS];
    logic [DATA_W-1:0]   regs_d [NREGS];

    cmd_t                cmd_in;
    logic [DATA_W-1:0]   rd_word;
    logic                serve_evt;
    logic                serve_cmd;
    logic                cap_nak;
    logic                to_clr;
    logic                to_en;
    logic                to_expired;
    logic                rsvd_unused;

    assign cmd_in      = cmd_t'(cmd);
    assign cap_nak     = cmd_is_nak(cmd_q, NREGS);
    // The reserved field is captured with the command but carries no meaning.
    assign rsvd_unused = ^cmd_q.rsvd;

    // Watchdog restarts in each SEND state and runs through the following WAIT state.
    assign to_clr = (state_q == SEND) || (state_q == SEND2) || (state_q == ESEND);
    assign to_en  = (state_q == WAIT) || (state_q == WAIT2) || (state_q == EWAIT);

    resp_timeout_cnt #(
        .TO_CYCLES (TO_CYCLES),
        .TO_W      (TO_W)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (to_clr),
        .en      (to_en),
        .expired (to_expired)
    );

    // Read mux over the captured register index.
    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (cmd_q.idx == IDX_W'(i)) begin
                rd_word = regs_q[i];
            end
        end
    end

    // Arbitration, command execution, response sequencing and event capture.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        resp_d      = resp_q;
        evt_pend_d  = evt_pend_q;
        evt_code_d  = evt_code_q;
        last_evt_d  = last_evt_q;
        regs_d      = regs_q;
        snd_resp_d  = 1'b0;
        strb_d      = '0;
        tx_err_d    = 1'b0;
        clr_cmd_rdy = 1'b0;
        serve_evt   = 1'b0;
        serve_cmd   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Round-robin when both are eligible: an event wins unless one was served last.
                serve_evt = evt_pend_q && (!cmd_rdy || !last_evt_q);
                serve_cmd = cmd_rdy && !serve_evt;
                if (serve_evt) begin
                    resp_d     = {EVT_HDR, evt_code_q};
                    evt_pend_d = 1'b0;
                    last_evt_d = 1'b1;
                    state_d    = ESEND;
                end else if (serve_cmd) begin
                    cmd_d       = cmd_in;
                    data_d      = data;
                    clr_cmd_rdy = 1'b1;
                    last_evt_d  = 1'b0;
                    state_d     = EXEC;
                    // Strobe is registered here so it is high during EXEC.
                    if ((cmd_in.op == OP_STROBE) && !cmd_is_nak(cmd_in, NREGS)) begin
                        for (int unsigned i = 0; i < NREGS; i++) begin
                            strb_d[i] = (cmd_in.idx == IDX_W'(i));
                        end
                    end
                end
            end
            EXEC: begin
                state_d = SEND;
                if (cap_nak) begin
                    resp_d = NAK;
                end else begin
                    unique case (cmd_q.op)
                        OP_WRITE: begin
                            for (int unsigned i = 0; i < NREGS; i++) begin
                                if (cmd_q.idx == IDX_W'(i)) begin
                                    regs_d[i] = data_q;
                                end
                            end
                            resp_d = ACK;
                        end
                        OP_READ:   resp_d = rd_word[15:8];
                        OP_STROBE: resp_d = ACK;
                        OP_RSVD:   resp_d = NAK;
                    endcase
                end
            end
            SEND:  state_d = WAIT;
            WAIT: begin
                if (resp_sent) begin
                    if (!cap_nak && (cmd_q.op == OP_READ)) begin
                        resp_d  = rd_word[7:0];
                        state_d = SEND2;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (to_expired) begin
                    tx_err_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            SEND2: state_d = WAIT2;
            WAIT2: begin
                if (resp_sent) begin
                    state_d = IDLE;
                end else if (to_expired) begin
                    tx_err_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            ESEND: state_d = EWAIT;
            EWAIT: begin
                if (resp_sent) begin
                    state_d = IDLE;
                end else if (to_expired) begin
                    tx_err_d = 1'b1;
                    state_d  = IDLE;
                end
            end
        endcase

        // A new request overrides a same-cycle clear and replaces any pending code.
        if (evt_req) begin
            evt_pend_d = 1'b1;
            evt_code_d = evt_code;
        end

        snd_resp_d = (state_d == SEND) || (state_d == SEND2) || (state_d == ESEND);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            data_q     <= '0;
            resp_q     <= '0;
            snd_resp_q <= 1'b0;
            strb_q     <= '0;
            tx_err_q   <= 1'b0;
            evt_pend_q <= 1'b0;
            evt_code_q <= '0;
            last_evt_q <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            resp_q     <= resp_d;
            snd_resp_q <= snd_resp_d;
            strb_q     <= strb_d;
            tx_err_q   <= tx_err_d;
            evt_pend_q <= evt_pend_d;
            evt_code_q <= evt_code_d;
            last_evt_q <= last_evt_d;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    for (genvar g = 0; g < int'(NREGS); g++) begin : g_regs_out
        assign regs_out[DATA_W*g +: DATA_W] = regs_q[g];
    end

    assign snd_resp = snd_resp_q;
    assign resp     = resp_q;
    assign strb     = strb_q;
    assign tx_err   = tx_err_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench: vector table plus hand sequences, with a response scoreboard.
module tb_cmd_sequencer;
    import cmd_seq_pkg::*;

    localparam int unsigned NREGS     = 8;
    localparam int unsigned TO_CYCLES = 16;
    localparam int unsigned TO_W      = 5;
    localparam int          NV        = 10;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    cmd_rdy = 1'b0;
    logic [7:0]              cmd = 8'h00;
    logic [15:0]             data = 16'h0000;
    logic                    clr_cmd_rdy;
    logic                    snd_resp;
    logic [7:0]              resp;
    logic                    resp_sent;
    logic                    evt_req = 1'b0;
    logic [3:0]              evt_code = 4'h0;
    logic [NREGS*16-1:0]     regs_out;
    logic [NREGS-1:0]        strb;
    logic                    tx_err;

    cmd_sequencer #(
        .NREGS     (NREGS),
        .TO_CYCLES (TO_CYCLES),
        .TO_W      (TO_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .data        (data),
        .clr_cmd_rdy (clr_cmd_rdy),
        .snd_resp    (snd_resp),
        .resp        (resp),
        .resp_sent   (resp_sent),
        .evt_req     (evt_req),
        .evt_code    (evt_code),
        .regs_out    (regs_out),
        .strb        (strb),
        .tx_err      (tx_err)
    );

    always #5 clk = ~clk;

    // UART TX model: drops resp_sent on the edge that samples snd_resp, raises it tx_lat cycles later.
    int tx_lat   = 3;
    bit tx_stall = 1'b0;
    int tx_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_sent <= 1'b1;
            tx_cnt    <= 0;
        end else if (snd_resp) begin
            resp_sent <= 1'b0;
            tx_cnt    <= tx_lat;
        end else if (!resp_sent && !tx_stall) begin
            if (tx_cnt == 0) resp_sent <= 1'b1;
            else             tx_cnt <= tx_cnt - 1;
        end
    end

    typedef struct {
        logic [7:0]  c;
        logic [15:0] d;
    } cmd_rec_t;

    typedef struct {
        logic [7:0]  c;
        logic [15:0] d;
        int          nb;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  strb;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  expq [$];
    cmd_rec_t    cmdq [$];
    logic [15:0] mregs [NREGS];
    vec_t        vec [NV];

    int          cyc = 0;
    int          clr_total = 0;
    int          clr_cyc = 0;
    int          snd_total = 0;
    int          snd_cyc = 0;
    int          first_snd_cyc = 0;
    int          strb_total = 0;
    int          tx_err_total = 0;
    int          tx_err_cyc = 0;
    logic [7:0]  strb_last = 8'h00;
    bit          first_pending = 1'b0;
    bit          seen = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [NREGS*16-1:0] exp_flat();
        logic [NREGS*16-1:0] f;
        for (int i = 0; i < int'(NREGS); i++) f[16*i +: 16] = mregs[i];
        return f;
    endfunction

    // One clock: monitor/scoreboard at negedge, wrapper model drives just after posedge.
    task automatic step();
        cmd_rec_t rec;
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            if (snd_resp) begin
                snd_total++;
                snd_cyc = cyc;
                if (first_pending) begin
                    first_snd_cyc = cyc;
                    first_pending = 1'b0;
                end
                chk("resp_sent_at_send", 128'(resp_sent), 128'(1'b1));
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got %02h expected none", resp);
                end else begin
                    chk("resp_byte", 128'(resp), 128'(expq.pop_front()));
                end
            end
            if (clr_cmd_rdy) begin
                clr_total++;
                clr_cyc       = cyc;
                first_pending = 1'b1;
            end
            if (strb != '0) begin
                strb_total++;
                strb_last = strb;
            end
            if (tx_err) begin
                tx_err_total++;
                tx_err_cyc = cyc;
            end
        end
        seen = cmd_rdy && clr_cmd_rdy;
        @(posedge clk);
        #2;
        if (!rst_n) begin
            cmd_rdy = 1'b0;
            seen    = 1'b0;
        end else if (seen) begin
            cmd_rdy = 1'b0;
            data    = 16'($urandom);
        end else if (!cmd_rdy && cmdq.size() != 0) begin
            rec     = cmdq.pop_front();
            cmd     = rec.c;
            data    = rec.d;
            cmd_rdy = 1'b1;
        end
    endtask

    task automatic pulse_evt(input logic [3:0] c);
        evt_req  = 1'b1;
        evt_code = c;
        step();
        evt_req  = 1'b0;
        evt_code = 4'h0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            step();
            ok = (cmdq.size() == 0) && !cmd_rdy && (expq.size() == 0) && resp_sent && !snd_resp;
        end
        chk(tag, 128'(ok), 128'(1'b1));
        step();
        step();
    endtask

    task automatic wait_expq(input int n, input string tag);
        for (int i = 0; i < 200 && expq.size() > n; i++) step();
        chk_int(tag, int'(expq.size() <= n), 1);
    endtask

    task automatic push_cmd(input logic [7:0] c, input logic [15:0] d);
        cmd_rec_t r;
        r.c = c;
        r.d = d;
        cmdq.push_back(r);
        if (c[7:6] == 2'b00) mregs[c[2:0]] = d;
    endtask

    initial begin
        int c0;
        int s0;
        int t0;

        vec[0] = '{8'h03, 16'h1234, 1, 8'hA5, 8'h00, 8'h00};
        vec[1] = '{8'h43, 16'h0000, 2, 8'h12, 8'h34, 8'h00};
        vec[2] = '{8'h85, 16'h0000, 1, 8'hA5, 8'h00, 8'h20};
        vec[3] = '{8'hC0, 16'hFFFF, 1, 8'h5A, 8'h00, 8'h00};
        vec[4] = '{8'h00, 16'hBEEF, 1, 8'hA5, 8'h00, 8'h00};
        vec[5] = '{8'h40, 16'h0000, 2, 8'hBE, 8'hEF, 8'h00};
        vec[6] = '{8'h07, 16'h00FF, 1, 8'hA5, 8'h00, 8'h00};
        vec[7] = '{8'h47, 16'h0000, 2, 8'h00, 8'hFF, 8'h00};
        vec[8] = '{8'h80, 16'h0000, 1, 8'hA5, 8'h00, 8'h01};
        vec[9] = '{8'h41, 16'h0000, 2, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < int'(NREGS); i++) mregs[i] = 16'h0000;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_clr_cmd_rdy", 128'(clr_cmd_rdy), 128'(1'b0));
        chk("rst_snd_resp", 128'(snd_resp), 128'(1'b0));
        chk("rst_resp", 128'(resp), 128'(8'h00));
        chk("rst_strb", 128'(strb), 128'(8'h00));
        chk("rst_tx_err", 128'(tx_err), 128'(1'b0));
        chk("rst_regs", 128'(regs_out), 128'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) step();

        // Table of single commands.
        for (int v = 0; v < NV; v++) begin
            c0 = clr_total;
            s0 = strb_total;
            push_cmd(vec[v].c, vec[v].d);
            expq.push_back(vec[v].b0);
            if (vec[v].nb == 2) expq.push_back(vec[v].b1);
            wait_idle($sformatf("vec%0d_idle", v));
            chk_int($sformatf("vec%0d_clr_pulses", v), clr_total - c0, 1);
            chk_int($sformatf("vec%0d_latency", v), first_snd_cyc - clr_cyc, 2);
            chk_int($sformatf("vec%0d_strb_cycles", v), strb_total - s0, (vec[v].strb != 8'h00) ? 1 : 0);
            if (vec[v].strb != 8'h00)
                chk($sformatf("vec%0d_strb_value", v), 128'(strb_last), 128'(vec[v].strb));
            chk($sformatf("vec%0d_regs", v), 128'(regs_out), 128'(exp_flat()));
        end

        // Event arriving during a READ, with another command queued: event goes first.
        tx_lat = 6;
        push_cmd(8'h43, 16'h0000);
        expq.push_back(8'h12);
        expq.push_back(8'h34);
        expq.push_back(8'hE7);
        expq.push_back(8'hA5);
        wait_expq(3, "arb_first_byte");
        push_cmd(8'h05, 16'h5555);
        pulse_evt(4'h7);
        wait_idle("arb_evt_first_idle");
        chk("arb_regs", 128'(regs_out), 128'(exp_flat()));

        // After serving an event, a contending command wins over a new event.
        pulse_evt(4'h3);
        expq.push_back(8'hE3);
        wait_expq(0, "rr_evt3_sent");
        push_cmd(8'h40, 16'h0000);
        expq.push_back(8'hBE);
        expq.push_back(8'hEF);
        expq.push_back(8'hE9);
        pulse_evt(4'h9);
        wait_idle("rr_cmd_first_idle");

        // Two events while busy: only the latest is reported, once.
        push_cmd(8'h43, 16'h0000);
        expq.push_back(8'h12);
        expq.push_back(8'h34);
        expq.push_back(8'hE2);
        wait_expq(2, "ovw_first_byte");
        pulse_evt(4'h1);
        pulse_evt(4'h2);
        wait_idle("ovw_idle");

        // Response timeout: WAIT is entered on the edge after SEND; tx_err rises 16 edges later.
        tx_stall = 1'b1;
        t0 = tx_err_total;
        push_cmd(8'h02, 16'h0BAD);
        expq.push_back(8'hA5);
        for (int i = 0; i < 200 && tx_err_total == t0; i++) step();
        chk_int("to_fired", tx_err_total - t0, 1);
        chk_int("to_delay", tx_err_cyc - snd_cyc, 17);
        step();
        step();
        chk_int("to_pulse_width", tx_err_total - t0, 1);
        chk("to_regs", 128'(regs_out), 128'(exp_flat()));
        tx_stall = 1'b0;
        wait_idle("to_recover_idle");
        push_cmd(8'h42, 16'h0000);
        expq.push_back(8'h0B);
        expq.push_back(8'hAD);
        wait_idle("to_next_cmd_idle");

        // Reset between the two bytes of a READ.
        push_cmd(8'h43, 16'h0000);
        expq.push_back(8'h12);
        wait_expq(0, "rst_mid_first_byte");
        step();
        step();
        s0 = snd_total;
        rst_n = 1'b0;
        #1;
        chk("rstmid_clr_cmd_rdy", 128'(clr_cmd_rdy), 128'(1'b0));
        chk("rstmid_snd_resp", 128'(snd_resp), 128'(1'b0));
        chk("rstmid_resp", 128'(resp), 128'(8'h00));
        chk("rstmid_strb", 128'(strb), 128'(8'h00));
        chk("rstmid_tx_err", 128'(tx_err), 128'(1'b0));
        chk("rstmid_regs", 128'(regs_out), 128'(0));
        for (int i = 0; i < int'(NREGS); i++) mregs[i] = 16'h0000;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (30) step();
        chk_int("rstmid_no_second_byte", snd_total - s0, 0);
        chk("rstmid_regs_after", 128'(regs_out), 128'(exp_flat()));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
